mlp_argmax: RTL and testbench

Downstream classification stage for the two-layer MLP. It consumes the MLP's float32 output vector one element per handshake and finds the largest element. For each sample it reports the index and value of that element. It converts `data_out` rows into class decisions for the host or the result buffer.

---
 rtl/mlp_argmax.sv | 138 +++++++++++++
 tb/tb_mlp_argmax.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mlp_argmax.sv
// Streaming float32 argmax: finds index and value of the largest of N elements per sample.
// Optional MLP_ARGMAX_NAN_CHECK_EN: NaN elements are skipped and flagged on out_nan.
module mlp_argmax #(
  parameter int N     = 4,
  parameter int IDX_W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [31:0]      out_value,
  output logic             out_nan,
  output logic             busy
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] r_best_idx;
  logic [31:0]      r_best_val;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic w_accept;
  logic w_last;
  logic w_take;

  // Strict float32 "a > b" on raw bits; signed zeros are equal, infinities sort naturally.
  function automatic logic f_greater(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  assign w_accept = in_valid && r_in_ready && (r_state == ACCUM);
  assign w_last   = (r_count == LAST);

`ifdef MLP_ARGMAX_NAN_CHECK_EN
  logic r_have_best;
  logic r_nan;
  logic w_is_nan;

  assign w_is_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_take = 1'b0;
    if (!w_is_nan)
      w_take = (r_count == '0) || !r_have_best || f_greater(in_data, r_best_val);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_have_best <= 1'b0;
      r_nan       <= 1'b0;
    end else if (w_accept) begin
      r_nan <= ((r_count == '0) ? 1'b0 : r_nan) | w_is_nan;
      if (w_take)
        r_have_best <= 1'b1;
      else if (r_count == '0)
        r_have_best <= 1'b0;
    end else if (r_state == HOLD && out_ready) begin
      r_nan <= 1'b0;
    end
  end

  assign out_nan = r_nan;
`else
  always_comb begin
    w_take = 1'b0;
    w_take = (r_count == '0) || f_greater(in_data, r_best_val);
  end

  assign out_nan = 1'b0;
`endif

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ACCUM;
      r_count     <= '0;
      r_best_idx  <= '0;
      r_best_val  <= 32'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
            if (w_take) begin
              r_best_val <= in_data;
              r_best_idx <= r_count;
            end else if (r_count == '0) begin
              // Only reachable for a NaN element 0: park the canonical all-NaN result.
              r_best_val <= 32'h7FC0_0000;
              r_best_idx <= '0;
            end
            if (w_last) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_busy <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= ACCUM;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_idx   = r_best_idx;
  assign out_value = r_best_val;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mlp_argmax.sv
// Directed self-checking bench for mlp_argmax (N=4), covering both NaN build options.
module tb_mlp_argmax;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [31:0]      out_value;
  logic             out_nan;
  logic             busy;

  int n_vec;
  int n_err;
  int n_stall;

  mlp_argmax #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_value(out_value),
    .out_nan  (out_nan),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one element and hold it until the handshake edge.
  task automatic push(input logic [31:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
      n_stall++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    push(a);
    push(b);
    push(c);
    push(d);
  endtask

  task automatic take(input string tag, input int exp_idx, input logic [31:0] exp_val,
                      input logic exp_nan);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_idx"},   32'(out_idx),   32'(exp_idx));
    check({tag, "_value"}, out_value,      exp_val);
    check({tag, "_nan"},   32'(out_nan),   32'(exp_nan));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drop"},  32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    n_stall   = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) step();

    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_idx",       32'(out_idx),   32'd0);
    check("rst_value",     out_value,      32'd0);
    check("rst_nan",       32'(out_nan),   32'd0);
    rst = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic sample with latency and busy checks.
    push(32'h3F80_0000);
    check("s1_busy", 32'(busy), 32'd1);
    push(32'h4120_0000);
    push(32'hC000_0000);
    push(32'h4000_0000);
    check("s1_latency", 32'(out_valid), 32'd1);
    check("s1_in_ready_low", 32'(in_ready), 32'd0);
    check("s1_busy_done", 32'(busy), 32'd0);
    take("s1", 1, 32'h4120_0000, 1'b0);

    push4(32'hBF80_0000, 32'hC000_0000, 32'hBF00_0000, 32'hC080_0000);
    take("neg", 2, 32'hBF00_0000, 1'b0);

    push4(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hBF80_0000);
    take("zero", 0, 32'h8000_0000, 1'b0);

    push4(32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000);
    take("tie", 0, 32'h40A0_0000, 1'b0);

    push4(32'h7F80_0000, 32'hFF80_0000, 32'h7F7F_FFFF, 32'h0000_0000);
    take("inf", 0, 32'h7F80_0000, 1'b0);

    // Backpressure: a huge element waits on in_valid while the result is held.
    push4(32'h4040_0000, 32'hBF80_0000, 32'h40E0_0000, 32'h3F00_0000);
    in_data  = 32'h7F00_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_idx", 32'(out_idx), 32'd2);
      check("bp_value", out_value, 32'h40E0_0000);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_stall = 0;
    push4(32'h3F00_0000, 32'h3E80_0000, 32'h3FC0_0000, 32'h3F80_0000);
    check("bp_back_to_back", 32'(n_stall), 32'd0);
    take("bp_next", 2, 32'h3FC0_0000, 1'b0);

    // Reset mid-sample discards the partial sample.
    push(32'h7F00_0000);
    push(32'h7F00_0000);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    step();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    check("mid_post_in_ready", 32'(in_ready), 32'd1);
    check("mid_post_busy", 32'(busy), 32'd0);
    push4(32'hC040_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC0A0_0000);
    take("mid", 1, 32'hBF80_0000, 1'b0);

`ifdef MLP_ARGMAX_NAN_CHECK_EN
    push4(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h4000_0000);
    take("nan", 3, 32'h4000_0000, 1'b1);
    check("nan_cleared", 32'(out_nan), 32'd0);
    push4(32'h7FC0_0000, 32'hFFC0_0000, 32'h7F80_0001, 32'h7FC0_0000);
    take("all_nan", 0, 32'h7FC0_0000, 1'b1);
`else
    push4(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h4000_0000);
    take("nan_raw", 0, 32'h7FC0_0000, 1'b0);
    push4(32'h7F80_0000, 32'h7F80_0001, 32'h3F80_0000, 32'h0000_0000);
    take("nan_beats_inf", 1, 32'h7F80_0001, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
